accum_window: RTL and testbench
===============================

ACCUM_WINDOW -- requirements
Module: accum_window

Interface
REQ-001 Parameter IN_WIDTH, default 16, sample width; SHALL match the accumulator's input width.
REQ-002 Parameter OUT_WIDTH, default 32, sum width; SHALL match the accumulator's output width.
REQ-003 Parameter WIN_LEN, default 8, samples per window, range 1..65535.
REQ-004 Parameter FIFO_DEPTH, default 4, result queue entries, power of two, 2 or more.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream sample valid.
REQ-008 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-009 in_data  input  IN_WIDTH  upstream sample.
REQ-010 flush  input  1  close the current window early.
REQ-011 acc_en  output  1  drives accumulator enable.
REQ-012 acc_data  output  IN_WIDTH  drives accumulator data input.
REQ-013 acc_clr  output  1  drives accumulator reset.
REQ-014 acc_q  input  OUT_WIDTH  accumulator output, registered in the accumulator.
REQ-015 res_valid  output  1  result available at the queue head.
REQ-016 res_ready  input  1  result consumed when res_valid && res_ready.
REQ-017 res_sum  output  OUT_WIDTH  window sum.
REQ-018 res_cnt  output  16  samples contained in the window.
REQ-019 res_ovf  output  1  window sum wrapped.

Function
REQ-020 acc_en SHALL equal in_valid && in_ready; acc_data SHALL equal in_data (combinational).
REQ-021 The FSM SHALL have two states: RUN and DUMP. In RUN, in_ready = 1; in DUMP, in_ready = 0.
REQ-022 The sample counter SHALL increment on each accepted sample in RUN.
REQ-023 RUN->DUMP SHALL occur when an accepted sample brings the count to WIN_LEN.
REQ-024 RUN->DUMP SHALL also occur on flush with (count + accepted sample) >= 1. A flush with zero samples SHALL be ignored.
REQ-025 On the cycle of flush, a sample accepted in the same cycle SHALL belong to the closing window.
REQ-026 In DUMP with the FIFO not full, the block SHALL, in that cycle:
- push {acc_q, count, ovf} to the FIFO;
- assert acc_clr;
- clear the count and the ovf flag;
- return to RUN.
REQ-027 In DUMP with the FIFO full, the block SHALL stay in DUMP with acc_clr = 0 and in_ready = 0 until a pop frees space.
REQ-028 A pop and a push in the same cycle with the FIFO full SHALL both take effect.
REQ-029 There SHALL be exactly one bubble cycle per window: the last sample at cycle t, push and clear at t+1, next sample accepted at t+2 at the earliest.
REQ-030 res_* SHALL present the FIFO head; res_valid SHALL be high when the FIFO is not empty.
REQ-031 FIFO order SHALL be first-in first-out. Pointers SHALL wrap modulo FIFO_DEPTH with no loss of entries.
REQ-032 flush SHALL be ignored while in DUMP.

Reset
REQ-033 While rst is high: state = RUN, count = 0, ovf = 0, FIFO emptied, res_valid = 0, acc_clr = 1.
REQ-034 While rst is high, in_ready = 0 and acc_en = 0.
REQ-035 Reset mid-window or in DUMP SHALL discard the partial window; res_sum, res_cnt and res_ovf SHALL read 0.

Configuration
REQ-036 With macro ACCUM_WINDOW_OVF_EN defined, on each accepted sample the block SHALL evaluate the (OUT_WIDTH+1)-bit sum acc_q + in_data (zero-extended); a carry out SHALL set a sticky per-window ovf flag, stored with the result.
REQ-037 Without ACCUM_WINDOW_OVF_EN, no overflow logic SHALL be built and res_ovf SHALL be constant 0.

Verification
REQ-038 WIN_LEN=4, samples 1,2,3,4, res_ready=1 -> one result: sum=10, cnt=4, ovf=0; in_ready=0 for exactly one cycle.
REQ-039 WIN_LEN=4, samples 5,6 then flush -> sum=11, cnt=2; next window starts from 0. A flush at count 0 -> no result.
REQ-040 FIFO_DEPTH=4, res_ready=0, five full windows -> four results queued; stall held in DUMP with in_ready=0; raise res_ready -> five results in order, none lost.
REQ-041 OUT_WIDTH=17, macro defined, samples 0xFFFF x3 with WIN_LEN=3 -> sum=0x0FFFD, ovf=1; next window ovf=0. Macro undefined -> ovf=0.
REQ-042 rst pulse after 2 of 4 samples, and again while stalled in DUMP -> FIFO empty, acc_clr=1 during rst, the next window counts from 0.

Source files
------------

// File: rtl/accum_window.sv
// Windowed accumulation controller: gates samples into an external accumulator and queues one {sum, count, ovf} result per window.
// Latency: the result is pushed one cycle after the window's last sample and is visible at the queue head the following cycle.
// Backpressure: in_ready drops for one bubble cycle per window, and stays low while the result queue is full until a pop frees a slot.
// Optional overflow tracking is enabled by defining ACCUM_WINDOW_OVF_EN.
module accum_window #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int WIN_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 flush,
    output logic                 acc_en,
    output logic [IN_WIDTH-1:0]  acc_data,
    output logic                 acc_clr,
    input  logic [OUT_WIDTH-1:0] acc_q,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_sum,
    output logic [15:0]          res_cnt,
    output logic                 res_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN, DUMP} state_t;

    state_t         state;
    logic [15:0]    count;
    logic [15:0]    count_inc;
    logic           win_done;
    logic           flush_close;

    logic [OUT_WIDTH-1:0] mem_sum [FIFO_DEPTH];
    logic [15:0]          mem_cnt [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          used;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;

    // Handshake, accumulator drive and queue control are all derived from the current state.
    always_comb begin
        in_ready    = !rst && (state == RUN);
        acc_en      = in_valid && in_ready;
        acc_data    = in_data;
        count_inc   = count + {15'd0, acc_en};
        win_done    = acc_en && (count_inc == 16'(WIN_LEN));
        // A flush only closes a window that holds at least one sample (including one accepted now).
        flush_close = flush && (count_inc != 16'd0);
        fifo_full   = (used == (AW+1)'(FIFO_DEPTH));
        res_valid   = !rst && (used != '0);
        pop         = res_valid && res_ready;
        // A pop in the same cycle frees the slot this push needs, even when the queue is full.
        push        = !rst && (state == DUMP) && (!fifo_full || pop);
        acc_clr     = rst || push;
    end

    // Window FSM: count accepted samples in RUN, hand the result to the queue in DUMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            count <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    count <= count_inc;
                    if (win_done || flush_close) begin
                        state <= DUMP;
                    end
                end
                DUMP: begin
                    if (push) begin
                        count <= 16'd0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ACCUM_WINDOW_OVF_EN
    logic ovf_flag;
    logic carry;
    logic mem_ovf [FIFO_DEPTH];

    // acc_q + in_data carries out of OUT_WIDTH bits exactly when acc_q exceeds the headroom left by in_data.
    always_comb begin
        carry = acc_en && (acc_q > ({OUT_WIDTH{1'b1}} - OUT_WIDTH'(in_data)));
    end

    // Sticky per-window overflow flag, cleared when its window is handed to the queue.
    always_ff @(posedge clk) begin
        if (rst || push) begin
            ovf_flag <= 1'b0;
        end else if (carry) begin
            ovf_flag <= 1'b1;
        end
    end

    // Overflow bit storage alongside each queued result.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ovf[wr_ptr] <= ovf_flag;
        end
    end

    assign res_ovf = res_valid && mem_ovf[rd_ptr];
`else
    assign res_ovf = 1'b0;
`endif

    // Result storage; contents need no reset because the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wr_ptr] <= acc_q;
            mem_cnt[wr_ptr] <= count;
        end
    end

    // Queue pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            used <= used + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign res_sum = res_valid ? mem_sum[rd_ptr] : '0;
    assign res_cnt = res_valid ? mem_cnt[rd_ptr] : 16'd0;

endmodule

// File: tb/tb_accum_window.sv
// Bench for accum_window: table-driven directed vectors, directed corner sequences and
// randomized traffic, all checked against a queue-based window/result model.
module tb_accum_window;

    localparam int WIN   = 4;
    localparam int DEPTH = 4;
    localparam int OW    = 17;
`ifdef ACCUM_WINDOW_OVF_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = 16'd0;
    logic          flush = 1'b0;
    logic          acc_en;
    logic [15:0]   acc_data;
    logic          acc_clr;
    logic [OW-1:0] acc_q = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [OW-1:0] res_sum;
    logic [15:0]   res_cnt;
    logic          res_ovf;

    accum_window #(
        .IN_WIDTH   (16),
        .OUT_WIDTH  (OW),
        .WIN_LEN    (WIN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .acc_en    (acc_en),
        .acc_data  (acc_data),
        .acc_clr   (acc_clr),
        .acc_q     (acc_q),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cnt   (res_cnt),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    // External accumulator the block drives.
    always_ff @(posedge clk) begin
        if (acc_clr) acc_q <= '0;
        else if (acc_en) acc_q <= acc_q + OW'(acc_data);
    end

    typedef struct {int sum; int cnt; int ovf;} res_t;
    typedef struct {int v; int d; int f; int rr; int rdy; int rv; int sum; int cnt;} vec_t;

    int   total = 0;
    int   bad = 0;
    int   n_pops = 0;
    int   last_sum, last_cnt, last_ovf;
    int   popped[$];
    int   m_win[$];
    res_t m_fifo[$];
    res_t m_pend;
    bit   m_dump = 1'b0;
    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic f, input logic rr);
        @(negedge clk);
        in_valid = v; in_data = d; flush = f; res_ready = rr;
        #1;
    endtask

    // Reference: window contents as a sample list, results as a queue, one pending result while dumping.
    task automatic model_cycle();
        int exp_rdy, exp_rv, pop, push, tot;
        exp_rdy = m_dump ? 0 : 1;
        exp_rv  = (m_fifo.size() != 0) ? 1 : 0;
        pop     = (exp_rv != 0 && res_ready) ? 1 : 0;
        push    = (m_dump && (m_fifo.size() < DEPTH || pop != 0)) ? 1 : 0;
        chk("in_ready", int'(in_ready), exp_rdy);
        chk("acc_en", int'(acc_en), (exp_rdy != 0 && in_valid) ? 1 : 0);
        chk("acc_clr", int'(acc_clr), push);
        chk("res_valid", int'(res_valid), exp_rv);
        if (exp_rv != 0) begin
            chk("res_sum", int'(res_sum), m_fifo[0].sum);
            chk("res_cnt", int'(res_cnt), m_fifo[0].cnt);
            chk("res_ovf", int'(res_ovf), m_fifo[0].ovf);
        end
        if (res_valid && res_ready) begin
            last_sum = int'(res_sum); last_cnt = int'(res_cnt); last_ovf = int'(res_ovf);
            popped.push_back(int'(res_sum));
            n_pops++;
        end
        if (pop != 0) void'(m_fifo.pop_front());
        if (push != 0) begin
            m_fifo.push_back(m_pend);
            m_dump = 1'b0;
        end
        if (exp_rdy != 0) begin
            if (in_valid) m_win.push_back(int'(in_data));
            if (m_win.size() == WIN || (flush && m_win.size() != 0)) begin
                tot = 0;
                foreach (m_win[k]) tot += m_win[k];
                m_pend.sum = tot % (1 << OW);
                m_pend.cnt = m_win.size();
                m_pend.ovf = (OVF_ON != 0 && tot >= (1 << OW)) ? 1 : 0;
                m_win.delete();
                m_dump = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic f, input logic rr);
        drive(v, d, f, rr);
        model_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; flush = 1'b1; res_ready = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_acc_en", int'(acc_en), 0);
        chk("rst_acc_clr", int'(acc_clr), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        @(negedge clk);
        #1;
        chk("rst_acc_clr2", int'(acc_clr), 1);
        chk("rst_res_valid2", int'(res_valid), 0);
        chk("rst_res_sum", int'(res_sum), 0);
        chk("rst_res_cnt", int'(res_cnt), 0);
        chk("rst_res_ovf", int'(res_ovf), 0);
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
        m_win.delete();
        m_fifo.delete();
        m_dump = 1'b0;
    endtask

    initial begin
        // Full window then a flushed short window, a zero-count flush, and a one-sample flush.
        tbl[0]  = '{1, 1, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 3, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 4, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{1, 5, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 5, 0, 1, 1, 1, 10, 4};
        tbl[6]  = '{1, 6, 1, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 1, 1, 1, 11, 2};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        tbl[10] = '{1, 7, 0, 1, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 1, 7, 1};

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].v != 0, 16'(tbl[i].d), tbl[i].f != 0, tbl[i].rr != 0);
            chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), tbl[i].rdy);
            chk($sformatf("tbl%0d_res_valid", i), int'(res_valid), tbl[i].rv);
            if (tbl[i].rv != 0) begin
                chk($sformatf("tbl%0d_res_sum", i), int'(res_sum), tbl[i].sum);
                chk($sformatf("tbl%0d_res_cnt", i), int'(res_cnt), tbl[i].cnt);
            end
            model_cycle();
        end

        // Five full windows into a stalled queue, then drain in order.
        do_reset();
        popped.delete();
        for (int j = 0; j < 30; j++) step(1'b1, 16'(j), 1'b0, 1'b0);
        drive(1'b1, 16'd99, 1'b0, 1'b0);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_res_valid", int'(res_valid), 1);
        model_cycle();
        for (int j = 0; j < 8; j++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("drain_count", popped.size(), 5);
        if (popped.size() == 5) begin
            chk("drain_0", popped[0], 6);
            chk("drain_1", popped[1], 26);
            chk("drain_2", popped[2], 46);
            chk("drain_3", popped[3], 66);
            chk("drain_4", popped[4], 86);
        end

        // Wrap of the running sum, then a clean window.
        do_reset();
        last_cnt = -1;
        for (int j = 0; j < 3; j++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("wrap_sum", last_sum, 'h0FFFD);
        chk("wrap_cnt", last_cnt, 3);
        chk("wrap_ovf", last_ovf, OVF_ON);
        for (int j = 0; j < 4; j++) step(1'b1, 16'd5, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("clean_sum", last_sum, 20);
        chk("clean_ovf", last_ovf, 0);

        // Reset mid-window, then reset while stalled in DUMP.
        do_reset();
        last_cnt = -1;
        step(1'b1, 16'd3, 1'b0, 1'b1);
        step(1'b1, 16'd3, 1'b0, 1'b1);
        do_reset();
        for (int j = 0; j < 4; j++) step(1'b1, 16'd1, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("post_rst_cnt", last_cnt, 4);
        chk("post_rst_sum", last_sum, 4);
        for (int j = 0; j < 26; j++) step(1'b1, 16'd1, 1'b0, 1'b0);
        chk("dump_stall_ready", int'(in_ready), 0);
        do_reset();
        last_cnt = -1;
        for (int j = 0; j < 4; j++) step(1'b1, 16'd2, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("post_dump_rst_cnt", last_cnt, 4);
        chk("post_dump_rst_sum", last_sum, 8);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                logic v, f, rr;
                logic [15:0] d;
                v  = ($urandom_range(0, 3) != 0);
                f  = ($urandom_range(0, 9) == 0);
                rr = ($urandom_range(0, 4) < 3);
                d  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                                  : 16'($urandom_range(0, 255));
                step(v, d, f, rr);
            end
        end
        for (int j = 0; j < 10; j++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("final_empty", int'(res_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
